// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   arbState_t : arbiter FSM states
//   grant_t    : which stage was served most recently
//   NOP_INSTR  : instruction returned to fetch when an access is aborted
//   DEFAULT_TIMEOUT / TIMER_W : watchdog default and counter width
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } arbState_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

  localparam int unsigned DEFAULT_TIMEOUT = 16;

  // Wide enough for the largest legal TIMEOUT (255).
  localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle watchdog counter for the memory port arbiter.
// Ports:
//   clk     : system clock
//   rst     : synchronous reset, active-low
//   clr     : clears the count (held while the arbiter is idle)
//   en      : counts one busy cycle without an acknowledge
//   expired : count has reached TIMEOUT-1
module mem_arb_timer
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TIMER_W-1:0] count;

  // Holds at the terminal value; the arbiter leaves the busy state
  // in the same cycle expired is seen, so saturation is only a guard.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign expired = (count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between the fetch
// stage (instruction reads) and the memory stage (loads/stores).
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   if_req/if_addr           : fetch read request and address
//   if_rdata/if_ready        : fetched word and 1-cycle completion pulse
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_be           : data request, store flag, address, data, byte enables
//   dm_rdata/dm_ready        : load data and 1-cycle completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be         : registered memory request bundle
//   mem_rdata/mem_ack        : memory read data and combinational completion
//   stall_pipe               : freeze pipeline while any request is outstanding
//   timeout_err              : sticky flag, set when an access is aborted
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall_pipe,
  output logic                timeout_err
);

  arbState_t state;
  grant_t    lastGrant;

  logic busy;
  logic expired;
  logic ackHit;
  logic abortHit;
  logic grantData;

  assign busy = (state != IDLE);

  // Completion is gated by rst so no ready pulse escapes during reset.
  assign ackHit   = rst && busy && mem_ack;
  assign abortHit = rst && busy && !mem_ack && expired;

  // Data wins unless fetch is also waiting and data was served last.
  assign grantData = dm_req && (!if_req || (lastGrant == GNT_I));

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!busy),
    .en      (busy && !mem_ack),
    .expired (expired)
  );

  // Responses are combinational so the ready pulse lands in the ack cycle.
  always_comb begin
    if_ready = 1'b0;
    dm_ready = 1'b0;
    if_rdata = '0;
    dm_rdata = '0;
    if (state == BUSY_I && (ackHit || abortHit)) begin
      if_ready = 1'b1;
      if_rdata = ackHit ? mem_rdata : DATA_W'(NOP_INSTR);
    end
    if (state == BUSY_D && (ackHit || abortHit)) begin
      dm_ready = 1'b1;
      dm_rdata = ackHit ? mem_rdata : '0;
    end
  end

  assign stall_pipe = (if_req && !if_ready) || (dm_req && !dm_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      lastGrant   <= GNT_I;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grantData) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
          end else if (if_req) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
          end
        end
        BUSY_D, BUSY_I: begin
          // An ack in the expiry cycle is a normal completion.
          if (mem_ack || expired) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            lastGrant <= (state == BUSY_D) ? GNT_D : GNT_I;
            if (!mem_ack) begin
              timeout_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_pipe;
  logic        timeout_err;

  int compared   = 0;
  int mismatched = 0;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ready    (if_ready),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_be       (dm_be),
    .dm_rdata    (dm_rdata),
    .dm_ready    (dm_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .stall_pipe  (stall_pipe),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // One single-access transaction. ackDelay = -1 means memory never acks.
  typedef struct {
    logic        isData;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          ackDelay;
    logic [31:0] memRdata;
    logic [3:0]  expBe;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s (#%0d): got %h, expected %h", name, id, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doAccess(input vec_t v, input int id);
    int readyAt;
    int expAt;
    logic rdy;
    logic other;
    logic [31:0] rd;
    step();
    if (v.isData) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_be = v.be;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    mem_ack   = 1'b0;
    mem_rdata = v.memRdata;
    #1;
    check("stallReq", id, 32'(stall_pipe), 32'd1);
    check("memReqIdle", id, 32'(mem_req), 32'd0);
    step();
    check("memReq", id, 32'(mem_req), 32'd1);
    check("memAddr", id, mem_addr, v.addr);
    check("memWe", id, 32'(mem_we), 32'(v.isData ? v.we : 1'b0));
    check("memBe", id, 32'(mem_be), 32'(v.expBe));
    if (v.isData && v.we) check("memWdata", id, mem_wdata, v.wdata);
    expAt   = (v.ackDelay < 0) ? int'(TIMEOUT) - 1 : v.ackDelay;
    readyAt = -1;
    for (int c = 0; c < 40 && readyAt < 0; c++) begin
      mem_ack = (c == v.ackDelay);
      #1;
      rdy   = v.isData ? dm_ready : if_ready;
      other = v.isData ? if_ready : dm_ready;
      rd    = v.isData ? dm_rdata : if_rdata;
      if (rdy) begin
        readyAt = c;
        check("rdata", id, rd, v.expRdata);
        check("stallDrop", id, 32'(stall_pipe), 32'd0);
        check("otherReady", id, 32'(other), 32'd0);
      end else begin
        check("stallWait", id, 32'(stall_pipe), 32'd1);
        check("addrStable", id, mem_addr, v.addr);
        check("beStable", id, 32'(mem_be), 32'(v.expBe));
        if (v.isData && v.we) check("wdataStable", id, mem_wdata, v.wdata);
        check("rdataZero", id, rd, 32'd0);
      end
      step();
    end
    if_req  = 1'b0;
    dm_req  = 1'b0;
    mem_ack = 1'b0;
    #1;
    check("readyCycle", id, 32'(readyAt), 32'(expAt));
    check("memReqDone", id, 32'(mem_req), 32'd0);
    check("singlePulse", id, 32'(v.isData ? dm_ready : if_ready), 32'd0);
    check("timeoutErr", id, 32'(timeout_err), 32'(v.expErr));
  endtask

  initial begin
    logic found;
    logic expD;
    // {isData, we, addr, wdata, be, ackDelay, memRdata, expBe, expRdata, expErr}
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'h0,    0, 32'h0050_0093, 4'hF,    32'h0050_0093, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0,         4'h0,    1, 32'h0050_0093, 4'hF,    32'h0050_0093, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         4'b0101, 2, 32'h1234_5678, 4'b0101, 32'h1234_5678, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 3, 32'hAAAA_5555, 4'b0011, 32'hAAAA_5555, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0024, 32'h0,         4'h0,   -1, 32'hFFFF_FFFF, 4'hF,    32'h0000_0013, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         4'hF,   -1, 32'hFFFF_FFFF, 4'hF,    32'h0000_0000, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         4'h0,    0, 32'h0000_0297, 4'hF,    32'h0000_0297, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0080, 32'h0,         4'h0,    0, 32'h00A0_0113, 4'hF,    32'h00A0_0113, 1'b0};

    rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_be = '0; mem_rdata = '0; mem_ack = 1'b0;

    // Reset state
    step();
    step();
    check("rstMemReq", 0, 32'(mem_req), 32'd0);
    check("rstMemWe", 0, 32'(mem_we), 32'd0);
    check("rstMemAddr", 0, mem_addr, 32'd0);
    check("rstErr", 0, 32'(timeout_err), 32'd0);
    check("rstReady", 0, 32'({if_ready, dm_ready}), 32'd0);
    check("rstStall", 0, 32'(stall_pipe), 32'd0);
    rst = 1'b1;

    // Contention from reset: grants alternate D, I, D, I with immediate acks.
    step();
    if_req = 1'b1; if_addr = 32'h0000_0800;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0400; dm_be = 4'hF;
    for (int g = 0; g < 4; g++) begin
      expD  = (g % 2 == 0);
      found = 1'b0;
      for (int k = 0; k < 4 && !found; k++) begin
        mem_ack = 1'b0;
        #1;
        check("contStall", g, 32'(stall_pipe), 32'd1);
        if (mem_req) found = 1'b1;
        else step();
      end
      check("contGrantSeen", g, 32'(found), 32'd1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h1000_0000 + 32'(g);
      #1;
      check("contAddr", g, mem_addr, expD ? 32'h0000_0400 : 32'h0000_0800);
      check("contDmReady", g, 32'(dm_ready), 32'(expD));
      check("contIfReady", g, 32'(if_ready), 32'(!expD));
      check("contRdata", g, expD ? dm_rdata : if_rdata, 32'h1000_0000 + 32'(g));
      check("contStallHeld", g, 32'(stall_pipe), 32'd1);
      step();
      mem_ack = 1'b0;
    end
    if_req = 1'b0;
    dm_req = 1'b0;

    // Table-driven single accesses
    for (int i = 0; i < 7; i++) doAccess(vecs[i], i + 1);

    // Reset while BUSY_D before ack
    step();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0500; dm_wdata = 32'h5555_AAAA; dm_be = 4'hF;
    step();
    check("midMemReq", 20, 32'(mem_req), 32'd1);
    check("midMemWe", 20, 32'(mem_we), 32'd1);
    rst = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    #1;
    check("midNoReady", 20, 32'(dm_ready), 32'd0);
    step();
    rst = 1'b1;
    #1;
    check("midMemReqClr", 20, 32'(mem_req), 32'd0);
    check("midMemWeClr", 20, 32'(mem_we), 32'd0);
    check("midErrClr", 20, 32'(timeout_err), 32'd0);
    check("midNoReady2", 20, 32'({if_ready, dm_ready}), 32'd0);
    doAccess(vecs[7], 8);

    // mem_ack while idle is ignored
    for (int i = 0; i < 3; i++) begin
      step();
      mem_ack = 1'b1;
      #1;
      check("idleAckReady", 30 + i, 32'({if_ready, dm_ready}), 32'd0);
      check("idleAckRdata", 30 + i, if_rdata | dm_rdata, 32'd0);
      check("idleAckMemReq", 30 + i, 32'(mem_req), 32'd0);
    end
    mem_ack = 1'b0;
    step();
    check("idleAckStay", 33, 32'(mem_req), 32'd0);
    check("idleAckErr", 33, 32'(timeout_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage RISC-V pipeline.
- Sequences each access with a request/ack handshake, alternates fairly when both stages are pending, and raises a pipeline stall while any stage waits.
- A timeout watchdog keeps the core from hanging on a dead memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT, 16, cycles in a busy state without mem_ack before the access is aborted; legal range 2..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the clk rising edge.
- if_req  in  1  fetch read request; held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; valid only when if_ready=1.
- if_ready  out  1  fetch access complete; 1-cycle pulse.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_be  in  DATA_W/8  store byte enables.
- dm_rdata  out  DATA_W  load data; valid only when dm_ready=1.
- dm_ready  out  1  data access complete; 1-cycle pulse.
- mem_req  out  1  request to memory; registered.
- mem_we  out  1  write strobe; registered.
- mem_addr  out  ADDR_W  memory address; registered.
- mem_wdata  out  DATA_W  memory write data; registered.
- mem_be  out  DATA_W/8  memory byte enables; registered.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion.
- stall_pipe  out  1  freezes F/D/E/M stage registers while any request is outstanding.
- timeout_err  out  1  sticky flag: an access was aborted.

Behaviour:
- FSM states: IDLE, BUSY_D, BUSY_I.
- Reset (rst=0 at an edge, including mid-access):
  - state returns to IDLE and the timer clears.
  - last_grant is set to I, so data wins first.
  - all mem_* outputs go to 0 and timeout_err clears.
  - if_ready and dm_ready are 0 during reset; an in-flight access is abandoned.
- IDLE arbitration, evaluated each cycle:
  - dm_req only -> BUSY_D.
  - if_req only -> BUSY_I.
  - both -> BUSY_D, unless last_grant=D, in which case BUSY_I. Strict alternation under contention; data wins ties from reset.
  - neither -> stay in IDLE.
- On entering BUSY_x, latch the requester's fields into the mem_* registers and set mem_req=1 from the next cycle.
  - Fetch accesses drive mem_we=0 and mem_be=all ones.
  - Load accesses drive mem_we=0 and mem_be=dm_be.
  - Outputs stay stable until ack or abort.
- In BUSY_x with mem_ack=1 (combinational response):
  - x_ready=1 and x_rdata=mem_rdata in the same cycle.
  - Next edge: mem_req=0, state -> IDLE, last_grant=x.
- Minimum latency: request seen in cycle 0, mem_req in cycle 1, earliest ready in cycle 1, next arbitration in cycle 2. There is one IDLE bubble between back-to-back accesses.
- mem_ack in IDLE is ignored.
- Timer counts busy cycles with mem_ack=0. When it reaches TIMEOUT-1 with still no ack:
  - x_ready pulses.
  - if_rdata = 32'h0000_0013 (NOP) or dm_rdata = 0.
  - timeout_err latches 1; state -> IDLE.
  - An ack in the same cycle takes precedence: normal completion, no error.
- If a requester drops its req mid-access, the memory transaction still completes; the ready pulse is emitted and may be ignored.
- stall_pipe = (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational.
- x_rdata is 0 whenever x_ready=0.

Decomposition:
- Package riscv_mem_pkg holds:
  - state enum (IDLE/BUSY_D/BUSY_I).
  - grant encoding (GNT_I/GNT_D).
  - NOP_INSTR = 32'h0000_0013.
  - default TIMEOUT.
- One sub-module, mem_arb_timer: busy-cycle counter with clear/enable inputs and an expired output. The FSM, mux and output registers stay in the top.

Test Plan:
- Reset then if_req=1 with addr 0x0000_0010 only; memory acks 1 cycle after mem_req with 0x0050_0093 -> mem_req in cycle 1 with mem_addr 0x10 and mem_we=0; if_ready=1 with if_rdata=0x0050_0093; stall_pipe drops the same cycle.
- if_req and dm_req both held from reset; every memory access acks immediately -> grant order D,I,D,I; stall_pipe=1 until each respective ready.
- Store dm_addr 0x100, wdata 0xDEAD_BEEF, be 4'b0011 -> mem_we=1 with mem_wdata/mem_be matching and stable for a 3-cycle ack delay; dm_ready pulses exactly once.
- Fetch with mem_ack never asserted, TIMEOUT=16 -> after 16 busy cycles if_ready=1, if_rdata=0x0000_0013, timeout_err=1 and sticky through later normal accesses.
- rst=0 asserted during BUSY_D before ack -> next cycle state IDLE, mem_req=0, no ready pulse, timeout_err=0; a fetch request afterward is served normally.
- mem_ack pulsed in IDLE with no request -> no ready pulse, no state change.
